// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory responder.
// Holds the dm_ctrl access-size codes (same values the CPU control unit
// drives), the MMIO register offsets, and the alignment helper.
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    // Byte offsets of the registers inside the 16-byte MMIO window
    localparam logic [3:0] MMIO_OFF_LED    = 4'h0;
    localparam logic [3:0] MMIO_OFF_CYCLE  = 4'h4;
    localparam logic [3:0] MMIO_OFF_STORES = 4'h8;

    // Bytes are always aligned; halves need bit 0 clear; everything else,
    // including unused codes, is treated as a word access.
    function automatic logic dm_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
        logic mis;
        case (ctrl)
            DM_BYTE, DM_BYTE_U: mis = 1'b0;
            DM_HALF, DM_HALF_U: mis = off[0];
            default:            mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: picks the addressed byte/half out of a 32-bit word and
// sign- or zero-extends it according to dm_ctrl. Misaligned accesses give 0.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  ctrl_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension
    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = 32'h0;
        if (!dm_misaligned(ctrl_i, off_i)) begin
            case (ctrl_i)
                DM_HALF:   data_o = {{16{half_sel[15]}}, half_sel};
                DM_HALF_U: data_o = {16'h0, half_sel};
                DM_BYTE:   data_o = {{24{byte_sel[7]}}, byte_sel};
                DM_BYTE_U: data_o = {24'h0, byte_sel};
                default:   data_o = word_i;
            endcase
        end
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: MEM-stage data memory with byte-lane stores, combinational
// extended loads and a sticky misaligned-store flag.
// Optional feature macro: DM_MMIO_EN adds a 16-byte MMIO window at MMIO_BASE
// holding the LED register, a free-running cycle counter and a store counter.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] Data_out,
    output logic        misalign,
    output logic [15:0] led
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          mis;
    logic          mmio_hit;
    logic          store_ok;
    logic          ram_we;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   ram_load;
    logic          misalign_q, misalign_d;

    assign idx      = Addr_in[AW+1:2];
    assign mis      = dm_misaligned(dm_ctrl, Addr_in[1:0]);
    assign store_ok = mem_w && !reset && !mis;
    assign ram_we   = store_ok && !mmio_hit;

    // Lane enables for the store: a lane is written when it falls inside the access
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be
            always_comb begin
                case (dm_ctrl)
                    DM_BYTE, DM_BYTE_U: be[gi] = (Addr_in[1:0] == gi[1:0]);
                    DM_HALF, DM_HALF_U: be[gi] = (Addr_in[1] == gi[1]);
                    default:            be[gi] = 1'b1;
                endcase
            end
        end
    endgenerate

    // Replicate store data so each enabled lane sees the right source byte
    always_comb begin
        case (dm_ctrl)
            DM_BYTE, DM_BYTE_U: wdata = {4{Data_in[7:0]}};
            DM_HALF, DM_HALF_U: wdata = {2{Data_in[15:0]}};
            default:            wdata = Data_in;
        endcase
    end

    // RAM write with per-lane enables; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    dm_load_ext u_load_ext (
        .word_i (mem_q[idx]),
        .off_i  (Addr_in[1:0]),
        .ctrl_i (dm_ctrl),
        .data_o (ram_load)
    );

    // Sticky flag: any misaligned store attempt sets it until reset
    assign misalign_d = misalign_q | (mem_w & mis);
    always_ff @(posedge clk) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end
    assign misalign = misalign_q;

`ifdef DM_MMIO_EN
    logic [15:0] led_q, led_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] stores_q, stores_d;
    logic [31:0] mmio_load;
    logic        unused_bits;

    assign mmio_hit = (Addr_in[31:4] == MMIO_BASE[31:4]);
    assign unused_bits = ^{MMIO_BASE[3:0]};

    // Next-state for LED, cycle counter and saturating store counter
    always_comb begin
        led_d    = led_q;
        cycle_d  = cycle_q + 32'd1;
        stores_d = stores_q;
        if (store_ok && mmio_hit && (Addr_in[3:2] == MMIO_OFF_LED[3:2]))
            led_d = Data_in[15:0];
        if (ram_we && (stores_q != 32'hFFFF_FFFF))
            stores_d = stores_q + 32'd1;
    end

    // MMIO register state
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= 16'h0;
            cycle_q  <= 32'h0;
            stores_q <= 32'h0;
        end else begin
            led_q    <= led_d;
            cycle_q  <= cycle_d;
            stores_q <= stores_d;
        end
    end

    // MMIO reads return the raw register, no extension
    always_comb begin
        case (Addr_in[3:2])
            MMIO_OFF_LED[3:2]:    mmio_load = {16'h0, led_q};
            MMIO_OFF_CYCLE[3:2]:  mmio_load = cycle_q;
            MMIO_OFF_STORES[3:2]: mmio_load = stores_q;
            default:              mmio_load = 32'h0;
        endcase
        if (mis) mmio_load = 32'h0;
    end

    assign Data_out = mmio_hit ? mmio_load : ram_load;
    assign led      = led_q;
`else
    logic unused_bits;

    assign mmio_hit    = 1'b0;
    assign unused_bits = ^{Addr_in[31:AW+2], MMIO_BASE};
    assign Data_out    = ram_load;
    assign led         = 16'h0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed self-checking bench for dm_responder.
// Drives inputs 1 ns after the rising edge and samples before the next edge.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [2:0]  dm_ctrl;
    logic [31:0] Data_out;
    logic        misalign;
    logic [15:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_w    (mem_w),
        .Addr_in  (Addr_in),
        .Data_in  (Data_in),
        .dm_ctrl  (dm_ctrl),
        .Data_out (Data_out),
        .misalign (misalign),
        .led      (led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        mem_w = 1'b1; Addr_in = a; Data_in = d; dm_ctrl = c;
        tick();
        mem_w = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] c,
                        input logic [31:0] exp);
        mem_w = 1'b0; Addr_in = a; dm_ctrl = c;
        #1;
        check(tag, Data_out, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] v1;

    initial begin
        reset = 1'b1; mem_w = 1'b0; Addr_in = 32'h0; Data_in = 32'h0; dm_ctrl = 3'b000;
        tick(); tick();
        reset = 1'b0;
        check("reset_misalign", {31'h0, misalign}, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);

        // Word store then extended sub-word loads
        store(32'h10, 32'h8765_4321, 3'b000);
        load("ld_word",     32'h10, 3'b000, 32'h8765_4321);
        load("ld_byte_s",   32'h13, 3'b011, 32'hFFFF_FF87);
        load("ld_byte_u",   32'h13, 3'b100, 32'h0000_0087);
        load("ld_half_s",   32'h12, 3'b001, 32'hFFFF_8765);
        load("ld_half_u",   32'h10, 3'b010, 32'h0000_4321);
        load("ld_byte_pos", 32'h10, 3'b011, 32'h0000_0021);

        // Byte store over zero word; old data visible in the store cycle
        store(32'h10, 32'h0, 3'b000);
        mem_w = 1'b1; Addr_in = 32'h11; Data_in = 32'h0000_00AA; dm_ctrl = 3'b011;
        #1;
        check("rdw_old", Data_out, 32'h0);
        tick();
        mem_w = 1'b0;
        load("byte_merge", 32'h10, 3'b000, 32'h0000_AA00);
        store(32'h16, 32'h0000_BEEF, 3'b001);
        load("half_store", 32'h14, 3'b000, 32'hBEEF_0000);

        // Misaligned store
        store(32'h20, 32'h1111_1111, 3'b000);
        check("pre_misalign", {31'h0, misalign}, 32'h0);
        store(32'h22, 32'hFFFF_FFFF, 3'b000);
        load("mis_no_write", 32'h20, 3'b000, 32'h1111_1111);
        check("misalign_set", {31'h0, misalign}, 32'h1);
        load("mis_load_zero", 32'h22, 3'b000, 32'h0);
        tick(); tick();
        check("misalign_sticky", {31'h0, misalign}, 32'h1);
        do_reset();
        check("misalign_clear", {31'h0, misalign}, 32'h0);

        // Aliasing modulo the 4 KiB RAM
        store(32'h1000, 32'hCAFE_F00D, 3'b000);
        load("alias", 32'h0, 3'b000, 32'hCAFE_F00D);

`ifdef DM_MMIO_EN
        store(BASE, 32'h1234_BEEF, 3'b000);
        check("led_write", {16'h0, led}, 32'h0000_BEEF);
        load("led_read", BASE, 3'b000, 32'h0000_BEEF);
        load("mmio_no_ram", BASE & 32'h0000_0FFF, 3'b000, 32'hCAFE_F00D);
        Addr_in = BASE + 32'h4; dm_ctrl = 3'b000;
        #1; v1 = Data_out;
        tick();
        check("cycle_incr", Data_out, v1 + 32'd1);
        do_reset();
        store(32'h40, 32'h1, 3'b000);
        store(32'h44, 32'h2, 3'b000);
        store(32'h48, 32'h3, 3'b000);
        store(32'h4A, 32'h4, 3'b000);
        load("stores_cnt", BASE + 32'h8, 3'b000, 32'd3);
        load("mmio_c_zero", BASE + 32'hC, 3'b000, 32'h0);
        do_reset();
`else
        check("led_tied", {16'h0, led}, 32'h0);
`endif

        // Reset asserted with a store pending: store dropped, state cleared
        store(32'h30, 32'h0, 3'b000);
`ifdef DM_MMIO_EN
        store(BASE, 32'h0000_5A5A, 3'b000);
`endif
        store(32'h32, 32'h0, 3'b000);
        reset = 1'b1; mem_w = 1'b1; Addr_in = 32'h30; Data_in = 32'h5555_AAAA; dm_ctrl = 3'b000;
        tick();
        reset = 1'b0; mem_w = 1'b0;
        load("rst_drop", 32'h30, 3'b000, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
`ifdef DM_MMIO_EN
        load("rst_cycle", BASE + 32'h4, 3'b000, 32'h0);
        load("rst_stores", BASE + 32'h8, 3'b000, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
